lane_alu_seq: RTL and testbench

Parametrised sequential ALU that succeeds the processor's combinational 16-bit/dual-8-bit ALU. It accepts one operation at a time through a valid/ready handshake and executes it on a full-width word or on `LANES` packed sub-words. Multiply is iterative over several cycles; all other ops complete in one. Per-lane carry and an illegal-op flag are returned with the result. It sits between the processor's decode/execute control and the register file write-back.

---
 rtl/lane_alu_pkg.sv | 16 +
 rtl/lane_alu_seq_if.sv | 21 ++
 rtl/lane_mul_seq.sv | 61 ++++++
 rtl/lane_alu_seq.sv | 109 ++++++++++
 tb/tb_lane_alu_seq.sv | 131 +++++++++++++
 5 files changed

// File: rtl/lane_alu_pkg.sv
// lane_alu_pkg: opcodes, FSM state encoding and lane-width helper shared by the lane ALU files.
package lane_alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_SH  = 4'd2;
  localparam logic [3:0] OP_SLT = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_NEG = 4'd8;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_e;
  function automatic int lane_width(input int width, input int lanes);
    return width / lanes;
  endfunction
endpackage

// File: rtl/lane_alu_seq_if.sv
// lane_alu_seq_if: request/result handshake bundle of the lane ALU.
//   master: requester (decode/execute side), slave: the ALU.
//   in_valid/in_ready/op/is_packed/a/b carry the request,
//   out_valid/out_ready/result/carry/illegal carry the result.
interface lane_alu_seq_if #(parameter int WIDTH = 16, parameter int LANES = 2);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             is_packed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [LANES-1:0] carry;
  logic             illegal;
  modport master (output in_valid, op, is_packed, a, b, out_ready,
                  input in_ready, out_valid, result, carry, illegal);
  modport slave  (input in_valid, op, is_packed, a, b, out_ready,
                  output in_ready, out_valid, result, carry, illegal);
endinterface

// File: rtl/lane_mul_seq.sv
// lane_mul_seq: iterative shift-add multiplier, full width or LANES parallel lanes.
//   start/is_packed/a/b: load operands (one cycle pulse),
//   done: high during the final iteration, product: accumulator value after that iteration.
module lane_mul_seq import lane_alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_packed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int LW = lane_width(WIDTH, LANES);
  localparam int CW = $clog2(WIDTH + 1);
  // lane MSB and LSB positions; carries and shifts are cut there in packed mode
  localparam logic [WIDTH-1:0] HI = {LANES{{1'b1, {(LW-1){1'b0}}}}};
  localparam logic [WIDTH-1:0] LO = {LANES{{{(LW-1){1'b0}}, 1'b1}}};
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [WIDTH-1:0] hi, lo, lane_sel, pp, sum;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, pk_q, pk_d;
  for (genvar g = 0; g < LANES; g++) begin : g_sel
    assign lane_sel[g*LW +: LW] = {LW{pk_q ? mplier_q[g*LW] : mplier_q[0]}};
  end
  always_comb begin
    hi = pk_q ? HI : '0;
    lo = pk_q ? LO : '0;
    pp = mcand_q & lane_sel;
    // add with lane MSBs summed separately so no carry crosses a lane boundary
    sum = ((acc_q & ~hi) + (pp & ~hi)) ^ ((acc_q ^ pp) & hi);
    mcand_d = start ? b : busy_q ? (mcand_q << 1) & ~lo : mcand_q;
    mplier_d = start ? a : busy_q ? (mplier_q >> 1) & ~hi : mplier_q;
    acc_d = start ? '0 : busy_q ? sum : acc_q;
    pk_d = start ? is_packed : pk_q;
    cnt_d = start ? (is_packed ? CW'(LW) : CW'(WIDTH)) : busy_q ? cnt_q - 1'b1 : cnt_q;
    busy_d = start | (busy_q & (cnt_q != CW'(1)));
    done = busy_q & (cnt_q == CW'(1));
    product = sum;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      pk_q <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      pk_q <= pk_d;
    end
  end
endmodule

// File: rtl/lane_alu_seq.sv
// lane_alu_seq: sequential full-width / packed-lane ALU behind a valid/ready handshake.
//   clk, reset (async, active low), bus: lane_alu_seq_if slave (request in, result out).
module lane_alu_seq import lane_alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int LANES = 2
) (
  input logic           clk,
  input logic           reset,
  lane_alu_seq_if.slave bus
);
  localparam int LW = lane_width(WIDTH, LANES);
  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             pk_q, pk_d, illegal_q, illegal_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [WIDTH-1:0] pk_result, full_r, ex_result, mul_product;
  logic [LANES-1:0] carry_q, carry_d, pk_carry, ex_carry;
  logic             full_c, in_ready, out_valid, accept, mul_done, mul_fin;
  // operands are zero-extended to w bits; returns the w-bit result with the add carry at bit w
  function automatic logic [WIDTH:0] lane_op(input logic [WIDTH-1:0] x, y, input logic [3:0] o, input int w);
    logic [WIDTH-1:0] m, mag, shv, r;
    logic [WIDTH:0]   s, cbit;
    logic             sgn, c;
    m = {WIDTH{1'b1}} >> (WIDTH - w);
    cbit = {m, 1'b1} & ~{1'b0, m};
    s = {1'b0, x} + {1'b0, y};
    sgn = |(x & (m ^ (m >> 1)));
    mag = sgn ? (~x + 1'b1) & m : x;
    shv = (mag >= WIDTH'(w)) ? '0 : sgn ? y >> mag : (y << mag) & m;
    r = (o == OP_SH)  ? shv :
        (o == OP_SLT) ? WIDTH'(y < x) :
        (o == OP_AND) ? x & y :
        (o == OP_OR)  ? x | y :
        (o == OP_XOR) ? x ^ y :
        (o == OP_NOT) ? ~y & m :
        (o == OP_NEG) ? (~y + 1'b1) & m :
                        s[WIDTH-1:0] & m;
    // illegal opcodes execute as add, including its carry
    c = ((o == OP_ADD) || (o > OP_NEG)) && |(s & cbit);
    return {1'b0, r} | (c ? cbit : '0);
  endfunction
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign {pk_carry[g], pk_result[g*LW +: LW]} =
      (LW+1)'(lane_op(WIDTH'(a_q[g*LW +: LW]), WIDTH'(b_q[g*LW +: LW]), op_q, LW));
  end
  assign {full_c, full_r} = lane_op(a_q, b_q, op_q, WIDTH);
  lane_mul_seq #(.WIDTH(WIDTH), .LANES(LANES)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && (bus.op == OP_MUL)),
    .is_packed (bus.is_packed),
    .a         (bus.a),
    .b         (bus.b),
    .done      (mul_done),
    .product   (mul_product)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == S_IDLE) ? (accept ? ((bus.op == OP_MUL) ? S_MUL : S_EXEC) : S_IDLE) :
              (state_q == S_EXEC) ? S_DONE :
              (state_q == S_MUL)  ? (mul_done ? S_DONE : S_MUL) :
                                    (bus.out_ready ? S_IDLE : S_DONE);
  end
  always_comb begin
    // state is already IDLE during reset; gate so requests are refused until release
    in_ready = reset && (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    accept = bus.in_valid && in_ready;
    mul_fin = (state_q == S_MUL) && mul_done;
  end
  always_comb begin
    ex_result = pk_q ? pk_result : full_r;
    ex_carry = pk_q ? pk_carry : LANES'(full_c);
    op_d = accept ? bus.op : op_q;
    pk_d = accept ? bus.is_packed : pk_q;
    a_d = accept ? bus.a : a_q;
    b_d = accept ? bus.b : b_q;
    result_d = (state_q == S_EXEC) ? ex_result : mul_fin ? mul_product : result_q;
    carry_d = (state_q == S_EXEC) ? ex_carry : mul_fin ? '0 : carry_q;
    illegal_d = (state_q == S_EXEC) ? (op_q > OP_NEG) : mul_fin ? 1'b0 : illegal_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= '0;
      pk_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      carry_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      op_q <= op_d;
      pk_q <= pk_d;
      a_q <= a_d;
      b_q <= b_d;
      result_q <= result_d;
      carry_q <= carry_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result = result_q;
  assign bus.carry = carry_q;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_lane_alu_seq.sv
// tb_lane_alu_seq: directed checks of lane_alu_seq with WIDTH=16, LANES=2.
module tb_lane_alu_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  lane_alu_seq_if #(.WIDTH(16), .LANES(2)) bus ();
  lane_alu_seq #(.WIDTH(16), .LANES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [3:0] o, input logic p, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    chk("in_ready before accept", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.is_packed = p;
    bus.a = x;
    bus.b = y;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op = 4'd3;
    bus.is_packed = ~p;
    bus.a = 16'hDEAD;
    bus.b = 16'hBEEF;
  endtask
  task automatic await(input string tag, input int lat, input logic [15:0] r, input logic [1:0] c, input logic il);
    int e;
    e = 1;
    @(negedge clk);
    chk({tag, " in_ready low while busy"}, 32'(bus.in_ready), 0);
    while (!bus.out_valid && e < 200) begin
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 32'(e), 32'(lat));
    chk({tag, " result"}, 32'(bus.result), 32'(r));
    chk({tag, " carry"}, 32'(bus.carry), 32'(c));
    chk({tag, " illegal"}, 32'(bus.illegal), 32'(il));
  endtask
  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " out_valid after consume"}, 32'(bus.out_valid), 0);
    chk({tag, " in_ready after consume"}, 32'(bus.in_ready), 1);
  endtask
  task automatic run(input string tag, input logic [3:0] o, input logic p, input logic [15:0] x,
                     input logic [15:0] y, input int lat, input logic [15:0] r, input logic [1:0] c,
                     input logic il);
    issue(o, p, x, y);
    await(tag, lat, r, c, il);
    consume(tag);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.is_packed = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(bus.in_ready), 0);
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset result", 32'(bus.result), 0);
    chk("reset carry", 32'(bus.carry), 0);
    chk("reset illegal", 32'(bus.illegal), 0);
    reset = 1'b1;
    #1;
    chk("in_ready after release", 32'(bus.in_ready), 1);
    run("add full", 4'd0, 1'b0, 16'hFFFF, 16'h0001, 2, 16'h0000, 2'b01, 1'b0);
    run("add packed", 4'd0, 1'b1, 16'h01FF, 16'h0101, 2, 16'h0200, 2'b01, 1'b0);
    run("mul full", 4'd1, 1'b0, 16'h0003, 16'h0005, 17, 16'h000F, 2'b00, 1'b0);
    run("mul packed", 4'd1, 1'b1, 16'h0203, 16'h0405, 9, 16'h080F, 2'b00, 1'b0);
    run("mul packed wrap", 4'd1, 1'b1, 16'h1010, 16'h1010, 9, 16'h0000, 2'b00, 1'b0);
    run("mul full wrap", 4'd1, 1'b0, 16'h1010, 16'h1010, 17, 16'h0100, 2'b00, 1'b0);
    run("sh full right", 4'd2, 1'b0, 16'hFFFE, 16'h0010, 2, 16'h0004, 2'b00, 1'b0);
    run("sh packed left", 4'd2, 1'b1, 16'h0201, 16'h0101, 2, 16'h0402, 2'b00, 1'b0);
    run("sh packed overrange", 4'd2, 1'b1, 16'h0008, 16'h01FF, 2, 16'h0100, 2'b00, 1'b0);
    run("slt true", 4'd3, 1'b0, 16'h0005, 16'h0003, 2, 16'h0001, 2'b00, 1'b0);
    run("slt false", 4'd3, 1'b0, 16'h0003, 16'h0005, 2, 16'h0000, 2'b00, 1'b0);
    run("and full", 4'd4, 1'b0, 16'hF0F0, 16'hFF00, 2, 16'hF000, 2'b00, 1'b0);
    run("or full", 4'd5, 1'b0, 16'hF0F0, 16'hFF00, 2, 16'hFFF0, 2'b00, 1'b0);
    run("xor full", 4'd6, 1'b0, 16'hF0F0, 16'hFF00, 2, 16'h0FF0, 2'b00, 1'b0);
    run("not full", 4'd7, 1'b0, 16'h0000, 16'h1234, 2, 16'hEDCB, 2'b00, 1'b0);
    run("neg packed", 4'd8, 1'b1, 16'h0000, 16'h0100, 2, 16'hFF00, 2'b00, 1'b0);
    run("neg full", 4'd8, 1'b0, 16'h0000, 16'h0100, 2, 16'hFF00, 2'b00, 1'b0);
    run("illegal op", 4'd12, 1'b0, 16'h0002, 16'h0003, 2, 16'h0005, 2'b00, 1'b1);
    issue(4'd0, 1'b0, 16'h0001, 16'h0002);
    await("backpressure", 2, 16'h0003, 2'b00, 1'b0);
    bus.in_valid = 1'b1;
    bus.op = 4'd6;
    bus.a = 16'h5555;
    bus.b = 16'hAAAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp out_valid", 32'(bus.out_valid), 1);
      chk("bp result", 32'(bus.result), 32'h0003);
      chk("bp carry", 32'(bus.carry), 0);
      chk("bp in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    consume("backpressure");
    issue(4'd1, 1'b0, 16'h0003, 16'h0005);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid-mul reset out_valid", 32'(bus.out_valid), 0);
    chk("mid-mul reset in_ready", 32'(bus.in_ready), 0);
    chk("mid-mul reset result", 32'(bus.result), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("idle after mid-mul reset", 32'(bus.in_ready), 1);
    repeat (20) @(negedge clk);
    chk("aborted mul stays silent", 32'(bus.out_valid), 0);
    run("add after reset", 4'd0, 1'b0, 16'h0001, 16'h0001, 2, 16'h0002, 2'b00, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
